// File: rtl/uart_io_conditioner.sv
// Board-pin conditioner for the UART SoC: switch sync + debounce with change pulse,
// RX sync (majority glitch filter when UART_RX_FILTER_EN is defined), registered TX/LEDs.
module uart_io_conditioner #(
    parameter int SW_W        = 7,
    parameter int LED_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SW_W-1:0]  i_sw,
    input  logic             i_rx,
    input  logic             i_tx,
    input  logic [LED_W-1:0] i_led,
    output logic [SW_W-1:0]  o_sw,
    output logic             o_sw_chg,
    output logic             o_rx,
    output logic             o_tx,
    output logic [LED_W-1:0] o_led
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0][SW_W-1:0] sw_sync_q;
    logic [SW_W-1:0]                  sw_sync;
    logic [SW_W-1:0]                  sw_q, sw_d;
    logic [SW_W-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [SW_W-1:0]                  upd;
    logic                             chg_q;
    logic [SYNC_STAGES-1:0]           rx_sync_q;
    logic                             rx_sync;
    logic                             tx_q;
    logic [LED_W-1:0]                 led_q;

    assign sw_sync = sw_sync_q[SYNC_STAGES-1];
    assign rx_sync = rx_sync_q[SYNC_STAGES-1];

    // A channel only commits after CNT_MAX+1 consecutive cycles of disagreement.
    always_comb begin
        sw_d  = sw_q;
        cnt_d = cnt_q;
        upd   = '0;
        for (int i = 0; i < SW_W; i++) begin
            if (sw_sync[i] == sw_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                sw_d[i]  = sw_sync[i];
                cnt_d[i] = '0;
                upd[i]   = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sw_sync_q <= '0;
            sw_q      <= '0;
            cnt_q     <= '0;
            chg_q     <= 1'b0;
            rx_sync_q <= '1;
            tx_q      <= 1'b1;
            led_q     <= '0;
        end else begin
            sw_sync_q <= {sw_sync_q[SYNC_STAGES-2:0], i_sw};
            sw_q      <= sw_d;
            cnt_q     <= cnt_d;
            chg_q     <= |upd;
            rx_sync_q <= {rx_sync_q[SYNC_STAGES-2:0], i_rx};
            tx_q      <= i_tx;
            led_q     <= i_led;
        end
    end

`ifdef UART_RX_FILTER_EN
    logic [2:0] rx_filt_q;
    logic       rx_maj;
    logic       rx_q;

    assign rx_maj = (rx_filt_q[0] & rx_filt_q[1]) |
                    (rx_filt_q[0] & rx_filt_q[2]) |
                    (rx_filt_q[1] & rx_filt_q[2]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_filt_q <= 3'b111;
            rx_q      <= 1'b1;
        end else begin
            rx_filt_q <= {rx_filt_q[1:0], rx_sync};
            rx_q      <= rx_maj;
        end
    end

    assign o_rx = rx_q;
`else
    assign o_rx = rx_sync;
`endif

    assign o_sw     = sw_q;
    assign o_sw_chg = chg_q;
    assign o_tx     = tx_q;
    assign o_led    = led_q;

endmodule

// File: tb/tb_uart_io_conditioner.sv
// Directed bench for uart_io_conditioner (SYNC_STAGES=2, DB_CYCLES=4); RX expectations
// follow whichever build (UART_RX_FILTER_EN defined or not) is compiled.
module tb_uart_io_conditioner;

    localparam int SW_W        = 7;
    localparam int LED_W       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int DB_CYCLES   = 4;
    localparam int SW_LAT      = SYNC_STAGES + DB_CYCLES;

    logic             clk;
    logic             rst;
    logic [SW_W-1:0]  i_sw;
    logic             i_rx;
    logic             i_tx;
    logic [LED_W-1:0] i_led;
    logic [SW_W-1:0]  o_sw;
    logic             o_sw_chg;
    logic             o_rx;
    logic             o_tx;
    logic [LED_W-1:0] o_led;

    int checks;
    int errors;

    uart_io_conditioner #(
        .SW_W(SW_W), .LED_W(LED_W), .SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .i_sw(i_sw), .i_rx(i_rx), .i_tx(i_tx), .i_led(i_led),
        .o_sw(o_sw), .o_sw_chg(o_sw_chg), .o_rx(o_rx), .o_tx(o_tx), .o_led(o_led)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Idle all inputs, reset, release; caller is then at "edge 0".
    task automatic do_reset();
        rst   = 1'b0;
        i_sw  = '0;
        i_rx  = 1'b1;
        i_tx  = 1'b1;
        i_led = '0;
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        i_sw  = 7'h7F;
        i_rx  = 1'b0;
        i_tx  = 1'b0;
        i_led = 16'hFFFF;
        tick(2);
        checks++;
        if (o_sw !== 7'h00) begin errors++; $display("FAIL reset_o_sw: got %h expected 00", o_sw); end
        checks++;
        if (o_sw_chg !== 1'b0) begin errors++; $display("FAIL reset_o_sw_chg: got %b expected 0", o_sw_chg); end
        checks++;
        if (o_rx !== 1'b1) begin errors++; $display("FAIL reset_o_rx: got %b expected 1", o_rx); end
        checks++;
        if (o_tx !== 1'b1) begin errors++; $display("FAIL reset_o_tx: got %b expected 1", o_tx); end
        checks++;
        if (o_led !== 16'h0000) begin errors++; $display("FAIL reset_o_led: got %h expected 0000", o_led); end
    endtask

    task automatic test_clean_switch();
        logic [SW_W-1:0] exp_sw;
        logic            exp_chg;
        do_reset();
        i_sw = 7'h05;
        for (int e = 1; e <= SW_LAT + 2; e++) begin
            tick(1);
            exp_sw  = (e >= SW_LAT) ? 7'h05 : 7'h00;
            exp_chg = (e == SW_LAT);
            checks++;
            if (o_sw !== exp_sw) begin
                errors++; $display("FAIL clean_o_sw edge %0d: got %h expected %h", e, o_sw, exp_sw);
            end
            checks++;
            if (o_sw_chg !== exp_chg) begin
                errors++; $display("FAIL clean_chg edge %0d: got %b expected %b", e, o_sw_chg, exp_chg);
            end
        end
    endtask

    task automatic test_bounce();
        logic [SW_W-1:0] exp_sw;
        logic            exp_chg;
        do_reset();
        // 1 after edge 0, 0 after edge 2, 1 (final, stable) after edge 4
        for (int e = 1; e <= 12; e++) begin
            if (e == 1) i_sw = 7'h01;
            if (e == 3) i_sw = 7'h00;
            if (e == 5) i_sw = 7'h01;
            tick(1);
            exp_sw  = (e >= 4 + SW_LAT) ? 7'h01 : 7'h00;
            exp_chg = (e == 4 + SW_LAT);
            checks++;
            if (o_sw !== exp_sw) begin
                errors++; $display("FAIL bounce_o_sw edge %0d: got %h expected %h", e, o_sw, exp_sw);
            end
            checks++;
            if (o_sw_chg !== exp_chg) begin
                errors++; $display("FAIL bounce_chg edge %0d: got %b expected %b", e, o_sw_chg, exp_chg);
            end
        end
    endtask

    task automatic test_simultaneous();
        int pulses;
        pulses = 0;
        do_reset();
        i_sw = 7'h48;
        tick(SW_LAT - 1);
        checks++;
        if (o_sw !== 7'h00) begin errors++; $display("FAIL simul_early: got %h expected 00", o_sw); end
        tick(1);
        checks++;
        if (o_sw !== 7'h48) begin errors++; $display("FAIL simul_o_sw: got %h expected 48", o_sw); end
        checks++;
        if (o_sw_chg !== 1'b1) begin errors++; $display("FAIL simul_chg: got %b expected 1", o_sw_chg); end
        for (int e = 0; e < 4; e++) begin
            tick(1);
            if (o_sw_chg === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL simul_extra_pulses: got %0d expected 0", pulses); end
    endtask

    task automatic rx_run(input string name, input int low_len, input int lo, input int hi);
        logic exp_rx;
        do_reset();
        for (int e = 1; e <= hi + 3; e++) begin
            i_rx = (e <= low_len) ? 1'b0 : 1'b1;
            tick(1);
            exp_rx = (e >= lo && e <= hi) ? 1'b0 : 1'b1;
            checks++;
            if (o_rx !== exp_rx) begin
                errors++; $display("FAIL %s edge %0d: got %b expected %b", name, e, o_rx, exp_rx);
            end
        end
    endtask

    task automatic test_rx();
`ifdef UART_RX_FILTER_EN
        rx_run("rx_glitch", 1, 100, 0);
        rx_run("rx_long", 10, 5, 14);
`else
        rx_run("rx_glitch", 1, 2, 2);
        rx_run("rx_long", 10, 2, 11);
`endif
    endtask

    task automatic test_tx_led();
        do_reset();
        i_tx  = 1'b0;
        i_led = 16'hA5C3;
        tick(1);
        checks++;
        if (o_tx !== 1'b0) begin errors++; $display("FAIL tx_low: got %b expected 0", o_tx); end
        checks++;
        if (o_led !== 16'hA5C3) begin errors++; $display("FAIL led_a: got %h expected a5c3", o_led); end
        i_tx  = 1'b1;
        i_led = 16'h3C5A;
        tick(1);
        checks++;
        if (o_tx !== 1'b1) begin errors++; $display("FAIL tx_high: got %b expected 1", o_tx); end
        checks++;
        if (o_led !== 16'h3C5A) begin errors++; $display("FAIL led_b: got %h expected 3c5a", o_led); end
    endtask

    task automatic test_reset_mid_count();
        logic [SW_W-1:0] exp_sw;
        logic            exp_chg;
        do_reset();
        i_sw = 7'h02;
        // rst low at edges 4 and 5
        for (int e = 1; e <= 13; e++) begin
            if (e == 4) rst = 1'b0;
            if (e == 6) rst = 1'b1;
            tick(1);
            exp_sw  = (e >= 11) ? 7'h02 : 7'h00;
            exp_chg = (e == 11);
            checks++;
            if (o_sw !== exp_sw) begin
                errors++; $display("FAIL midrst_o_sw edge %0d: got %h expected %h", e, o_sw, exp_sw);
            end
            checks++;
            if (o_sw_chg !== exp_chg) begin
                errors++; $display("FAIL midrst_chg edge %0d: got %b expected %b", e, o_sw_chg, exp_chg);
            end
        end
    endtask

    task automatic test_reset_during_pulse();
        do_reset();
        i_sw = 7'h10;
        tick(SW_LAT - 1);
        rst = 1'b0;
        tick(1);
        checks++;
        if (o_sw_chg !== 1'b0) begin errors++; $display("FAIL rstpulse_chg: got %b expected 0", o_sw_chg); end
        checks++;
        if (o_sw !== 7'h00) begin errors++; $display("FAIL rstpulse_o_sw: got %h expected 00", o_sw); end
        rst = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        i_sw   = '0;
        i_rx   = 1'b1;
        i_tx   = 1'b1;
        i_led  = '0;
        test_reset();
        test_clean_switch();
        test_bounce();
        test_simultaneous();
        test_rx();
        test_tx_led();
        test_reset_mid_count();
        test_reset_during_pulse();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
